// File: rtl/cvbs_pkg.sv
// Shared types and default NTSC 4fsc timing constants for the composite-video timing generator.
package cvbs_pkg;

  typedef enum logic [2:0] {
    StPreEq,
    StVsync,
    StPostEq,
    StVblank,
    StActive,
    StBottom
  } vstate_t;

  localparam int unsigned NtscHTotal     = 910;
  localparam int unsigned NtscHsyncLen   = 67;
  localparam int unsigned NtscEqLen      = 33;
  localparam int unsigned NtscSerrLen    = 67;
  localparam int unsigned NtscBurstStart = 76;
  localparam int unsigned NtscBurstLen   = 36;
  localparam int unsigned NtscActStart   = 150;
  localparam int unsigned NtscActLen     = 752;
  localparam int unsigned NtscVTotal     = 262;
  localparam int unsigned NtscVActStart  = 20;
  localparam int unsigned NtscVActLen    = 240;

endpackage

// File: rtl/cvbs_hcounter.sv
// Horizontal clock counter with line-boundary flags and the per-line sync/burst/active windows.
module cvbs_hcounter
  import cvbs_pkg::*;
#(
  parameter int unsigned H_TOTAL     = NtscHTotal,
  parameter int unsigned HSYNC_LEN   = NtscHsyncLen,
  parameter int unsigned EQ_LEN      = NtscEqLen,
  parameter int unsigned SERR_LEN    = NtscSerrLen,
  parameter int unsigned BURST_START = NtscBurstStart,
  parameter int unsigned BURST_LEN   = NtscBurstLen,
  parameter int unsigned ACT_START   = NtscActStart,
  parameter int unsigned ACT_LEN     = NtscActLen
) (
  input  logic                       clk,
  input  logic                       RESETn,
  input  logic                       enable,
  output logic [$clog2(H_TOTAL)-1:0] hcnt,
  output logic                       line_first,
  output logic                       line_last,
  output logic                       eq_low,
  output logic                       vs_low,
  output logic                       hs_low,
  output logic                       burst_win,
  output logic                       act_win
);

  localparam int unsigned HW   = $clog2(H_TOTAL);
  localparam int unsigned Half = H_TOTAL / 2;

  logic [HW-1:0] hcnt_d;

  always_comb begin
    hcnt_d = hcnt;
    if (enable) hcnt_d = line_last ? '0 : hcnt + 1'b1;
  end

  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) hcnt <= '0;
    else         hcnt <= hcnt_d;
  end

  assign line_first = (hcnt == '0);
  assign line_last  = (hcnt == HW'(H_TOTAL - 1));

  // Inclusive upper bounds keep the constants in range when a window ends at H_TOTAL.
  assign eq_low    = (hcnt < HW'(EQ_LEN)) ||
                     (hcnt >= HW'(Half) && hcnt <= HW'(Half + EQ_LEN - 1));
  assign vs_low    = (hcnt < HW'(Half - SERR_LEN)) ||
                     (hcnt >= HW'(Half) && hcnt < HW'(H_TOTAL - SERR_LEN));
  assign hs_low    = (hcnt < HW'(HSYNC_LEN));
  assign burst_win = (hcnt >= HW'(BURST_START)) && (hcnt <= HW'(BURST_START + BURST_LEN - 1));
  assign act_win   = (hcnt >= HW'(ACT_START)) && (hcnt <= HW'(ACT_START + ACT_LEN - 1));

endmodule

// File: rtl/cvbs_timing_gen.sv
// Composite-video timing generator: vertical FSM, field/interlace control, subcarrier phase
// and the registered sync/blank/burst/active/coordinate outputs.
module cvbs_timing_gen
  import cvbs_pkg::*;
#(
  parameter int unsigned H_TOTAL     = NtscHTotal,
  parameter int unsigned HSYNC_LEN   = NtscHsyncLen,
  parameter int unsigned EQ_LEN      = NtscEqLen,
  parameter int unsigned SERR_LEN    = NtscSerrLen,
  parameter int unsigned BURST_START = NtscBurstStart,
  parameter int unsigned BURST_LEN   = NtscBurstLen,
  parameter int unsigned ACT_START   = NtscActStart,
  parameter int unsigned ACT_LEN     = NtscActLen,
  parameter int unsigned V_TOTAL     = NtscVTotal,
  parameter int unsigned V_ACT_START = NtscVActStart,
  parameter int unsigned V_ACT_LEN   = NtscVActLen,
  parameter int unsigned PHASE_W     = 2,
  parameter int unsigned PHASE_INC   = 1
) (
  input  logic                         clk,
  input  logic                         RESETn,
  input  logic                         enable,
  input  logic                         color_enable,
  input  logic                         interlace,
  output logic                         sync_n,
  output logic                         blank,
  output logic                         burst_gate,
  output logic                         active,
  output logic [$clog2(ACT_LEN)-1:0]   px_x,
  output logic [$clog2(V_ACT_LEN)-1:0] px_y,
  output logic                         field,
  output logic                         line_start,
  output logic                         field_start,
  output logic [PHASE_W-1:0]           sc_phase
);

  localparam int unsigned HW = $clog2(H_TOTAL);
  localparam int unsigned VW = $clog2(V_TOTAL + 2);
  localparam int unsigned XW = $clog2(ACT_LEN);
  localparam int unsigned YW = $clog2(V_ACT_LEN);

  logic [HW-1:0] hcnt;
  logic line_first, line_last, eq_low, vs_low, hs_low, burst_win, act_win;

  cvbs_hcounter #(
    .H_TOTAL    (H_TOTAL),
    .HSYNC_LEN  (HSYNC_LEN),
    .EQ_LEN     (EQ_LEN),
    .SERR_LEN   (SERR_LEN),
    .BURST_START(BURST_START),
    .BURST_LEN  (BURST_LEN),
    .ACT_START  (ACT_START),
    .ACT_LEN    (ACT_LEN)
  ) u_hcounter (
    .clk       (clk),
    .RESETn    (RESETn),
    .enable    (enable),
    .hcnt      (hcnt),
    .line_first(line_first),
    .line_last (line_last),
    .eq_low    (eq_low),
    .vs_low    (vs_low),
    .hs_low    (hs_low),
    .burst_win (burst_win),
    .act_win   (act_win)
  );

  vstate_t          vstate_q, vstate_d;
  logic [VW-1:0]    vline_q, vline_d;
  logic             field_q, field_d, interlace_q, interlace_d, color_q, color_d;
  logic [PHASE_W-1:0] phase_q, phase_d;

  logic             sync_q, sync_d, blank_q, blank_d, burst_q, burst_d, active_q, active_d;
  logic             lstart_q, lstart_d, fstart_q, fstart_d;
  logic [XW-1:0]    px_x_q, px_x_d;
  logic [YW-1:0]    px_y_q, px_y_d;

  // Odd fields of an interlaced frame carry one extra line.
  logic v_last;
  assign v_last = (vline_q == VW'(V_TOTAL - 1) + VW'(interlace_q & field_q));

  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      vstate_q    <= StPreEq;
      vline_q     <= '0;
      field_q     <= 1'b0;
      interlace_q <= 1'b0;
      color_q     <= 1'b0;
      phase_q     <= '0;
      sync_q      <= 1'b1;
      blank_q     <= 1'b1;
      burst_q     <= 1'b0;
      active_q    <= 1'b0;
      lstart_q    <= 1'b0;
      fstart_q    <= 1'b0;
      px_x_q      <= '0;
      px_y_q      <= '0;
    end else begin
      vstate_q    <= vstate_d;
      vline_q     <= vline_d;
      field_q     <= field_d;
      interlace_q <= interlace_d;
      color_q     <= color_d;
      phase_q     <= phase_d;
      sync_q      <= sync_d;
      blank_q     <= blank_d;
      burst_q     <= burst_d;
      active_q    <= active_d;
      lstart_q    <= lstart_d;
      fstart_q    <= fstart_d;
      px_x_q      <= px_x_d;
      px_y_q      <= px_y_d;
    end
  end

  always_comb begin
    vstate_d    = vstate_q;
    vline_d     = vline_q;
    field_d     = field_q;
    interlace_d = interlace_q;
    color_d     = color_q;
    phase_d     = phase_q;
    if (enable) begin
      phase_d = phase_q + PHASE_W'(PHASE_INC);
      if (line_first) color_d = color_enable;
      if (line_first && vline_q == '0) interlace_d = interlace;
      if (line_last) begin
        vline_d = v_last ? '0 : vline_q + 1'b1;
        if (v_last) field_d = ~field_q;
        unique case (vstate_q)
          StPreEq:  if (vline_q == VW'(2)) vstate_d = StVsync;
          StVsync:  if (vline_q == VW'(5)) vstate_d = StPostEq;
          StPostEq: if (vline_q == VW'(8)) vstate_d = StVblank;
          StVblank: if (vline_q == VW'(V_ACT_START - 1)) vstate_d = StActive;
          StActive: if (vline_q == VW'(V_ACT_START + V_ACT_LEN - 1)) vstate_d = StBottom;
          StBottom: vstate_d = StBottom;
          default:  vstate_d = StPreEq;
        endcase
        if (v_last) vstate_d = StPreEq;
      end
      if (!interlace_q) field_d = 1'b0;
    end
  end

  always_comb begin
    sync_d   = sync_q;
    blank_d  = blank_q;
    burst_d  = burst_q;
    active_d = active_q;
    px_x_d   = px_x_q;
    px_y_d   = px_y_q;
    lstart_d = 1'b0;
    fstart_d = 1'b0;
    if (enable) begin
      unique case (vstate_q)
        StPreEq, StPostEq: sync_d = ~eq_low;
        StVsync:           sync_d = ~vs_low;
        default:           sync_d = ~hs_low;
      endcase
      burst_d  = burst_win & color_q & (vstate_q inside {StVblank, StActive, StBottom});
      active_d = act_win & (vstate_q == StActive);
      blank_d  = ~active_d;
      px_x_d   = active_d ? XW'(hcnt - HW'(ACT_START)) : '0;
      px_y_d   = active_d ? YW'(vline_q - VW'(V_ACT_START)) : '0;
      lstart_d = line_first;
      fstart_d = line_first & (vline_q == '0);
    end
  end

  assign sync_n      = sync_q;
  assign blank       = blank_q;
  assign burst_gate  = burst_q;
  assign active      = active_q;
  assign px_x        = px_x_q;
  assign px_y        = px_y_q;
  assign field       = field_q;
  assign line_start  = lstart_q;
  assign field_start = fstart_q;
  assign sc_phase    = phase_q;

endmodule
